// File: rtl/mul_pkg.sv
// Shared definitions for the Booth multiplier: FSM state encoding and default width.
package mul_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand,
// then arithmetic right shift of the {A, Q, Q_-1} chain by one bit.
module booth_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   m,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] sum;

    // Select A+M / A-M / A from the Booth pair, then shift the whole chain right.
    always_comb begin
        sum = a;
        case ({q[0], q_m1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        a_next    = {sum[WIDTH], sum[WIDTH:1]};
        q_next    = {sum[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed Booth multiplier: one Booth step per RUN cycle, result
// registered into P with a one-cycle done pulse when the operation retires.
module booth_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH:0]     m_q;      // sign-extended multiplicand, so A-M cannot overflow
    logic [WIDTH:0]     a_q;
    logic [WIDTH-1:0]   q_q;
    logic               q_m1_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] p_q;
    logic               done_q;

    logic [WIDTH:0]     a_next;
    logic [WIDTH-1:0]   q_next;
    logic               q_m1_next;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a         (a_q),
        .m         (m_q),
        .q         (q_q),
        .q_m1      (q_m1_q),
        .a_next    (a_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; RUN ends on the step that takes the counter to zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load operands on accept, step while running, publish result
    // on the edge leaving DONE so P never shows partial products.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q    <= '0;
            a_q    <= '0;
            q_q    <= '0;
            q_m1_q <= 1'b0;
            cnt_q  <= '0;
            p_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q    <= {M[WIDTH-1], M};
                        q_q    <= Q;
                        a_q    <= '0;
                        q_m1_q <= 1'b0;
                        cnt_q  <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    a_q    <= a_next;
                    q_q    <= q_next;
                    q_m1_q <= q_m1_next;
                    cnt_q  <= cnt_q - CW'(1);
                end
                DONE: begin
                    p_q    <= {a_q[WIDTH-1:0], q_q};
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign P    = p_q;
    assign done = done_q;
    assign busy = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and exhaustive checks of booth_multiplier at WIDTH=4.
module tb_booth_multiplier;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   M, Q;
    logic [2*W-1:0] P;
    logic           busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs [9];

    booth_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .M     (M),
        .Q     (Q),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
        int mi, qi;
        mi = $signed(m);
        qi = $signed(q);
        return (2*W)'(mi * qi);
    endfunction

    // Pulse start for one edge, then wait (bounded) for done.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                          output logic [2*W-1:0] p, output int lat, output int busy_cnt);
        M = m; Q = q; start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
        p = P;
    endtask

    initial begin
        logic [2*W-1:0] p, first_p;
        logic [W-1:0]   opm [18];
        logic [W-1:0]   opq [18];
        int lat, bc, ndone;

        vecs[0] = '{4'd3,     4'd5,     8'h0F};
        vecs[1] = '{4'(-3),   4'd5,     8'hF1};
        vecs[2] = '{4'(-8),   4'(-8),   8'h40};
        vecs[3] = '{4'(-8),   4'd7,     8'hC8};
        vecs[4] = '{4'd0,     4'(-1),   8'h00};
        vecs[5] = '{4'd7,     4'd7,     8'h31};
        vecs[6] = '{4'(-1),   4'(-1),   8'h01};
        vecs[7] = '{4'd7,     4'(-8),   8'hC8};
        vecs[8] = '{4'd1,     4'(-8),   8'hF8};

        // Reset state
        rst = 1'b1; start = 1'b0; M = '0; Q = '0;
        step(); step();
        check("reset_P", 32'(P), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b0;

        // Directed table: product, latency, busy span, done pulse width
        foreach (vecs[i]) begin
            run_op(vecs[i].m, vecs[i].q, p, lat, bc);
            check($sformatf("vec%0d_P", i), 32'(p), 32'(vecs[i].p));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd5);
            step();
            check($sformatf("vec%0d_done_width", i), 32'(done), 32'h0);
            check($sformatf("vec%0d_P_hold", i), 32'(P), 32'(vecs[i].p));
        end

        // start during RUN is ignored
        M = 4'd3; Q = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        M = 4'd7; Q = 4'd7; start = 1'b1;
        step();
        start = 1'b0; M = '0; Q = '0;
        ndone = 0; first_p = '0;
        for (int k = 0; k < 14; k++) begin
            if (done) begin
                if (ndone == 0) first_p = P;
                ndone++;
            end
            step();
        end
        check("busy_ignore_P", 32'(first_p), 32'h0F);
        check("busy_ignore_done_count", 32'(ndone), 32'd1);

        // Reset during the third RUN cycle abandons the operation
        M = 4'(-3); Q = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_P", 32'(P), 32'h0);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) ndone++;
            step();
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run_op(4'(-3), 4'd5, p, lat, bc);
        check("after_abort_P", 32'(p), 32'hF1);
        check("after_abort_latency", 32'(lat), 32'd5);
        step();

        // start held high, operands changing every cycle: accepts at edges 0, 6, 12
        start = 1'b1;
        for (int k = 0; k < 18; k++) begin
            opm[k] = 4'(k * 3 + 1);
            opq[k] = 4'(7 - k);
            M = opm[k]; Q = opq[k];
            step();
            check($sformatf("stream_done_%0d", k), 32'(done), 32'(k % 6 == 5));
            if (k % 6 == 5)
                check($sformatf("stream_P_%0d", k), 32'(P), 32'(ref_mul(opm[k-5], opq[k-5])));
        end
        start = 1'b0;
        step();

        // Exhaustive sweep against the reference product
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), p, lat, bc);
                check($sformatf("sweep_%0d_%0d", a, b), 32'(p), 32'(ref_mul(4'(a), 4'(b))));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits (signed two's complement), legal range 2..16.
REQ-002 clk  input  1  rising-edge clock, the only clock in the block.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to multiply M by Q; sampled only in IDLE.
REQ-005 M  input  WIDTH  signed multiplicand; sampled on the accepting edge.
REQ-006 Q  input  WIDTH  signed multiplier; sampled on the accepting edge.
REQ-007 P  output  2*WIDTH  signed product, registered.
REQ-008 busy  output  1  high while a multiplication is in progress (states RUN and DONE).
REQ-009 done  output  1  one-cycle pulse marking that P holds a new result.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-011 Transitions SHALL be:
- IDLE -> RUN on start=1.
- RUN -> DONE when the step counter reaches 0 after the final step.
- DONE -> IDLE unconditionally after one cycle.
REQ-012 On the accepting edge, the block SHALL:
- capture M into a (WIDTH+1)-bit sign-extended register;
- load the multiplier register with Q;
- clear the accumulator A (WIDTH+1 bits) and the extra bit Q_-1;
- set the step counter to WIDTH.
REQ-013 Each RUN cycle SHALL perform one Booth step on {Q[0], Q_-1}:
- 01: A = A + M.
- 10: A = A - M.
- 00 or 11: A unchanged.
- Then arithmetic-shift {A, Q, Q_-1} right by one bit and decrement the counter.
REQ-014 The accumulator SHALL be WIDTH+1 bits wide, so that A - M does not overflow when M is the most negative value.
REQ-015 Exactly WIDTH RUN cycles SHALL occur per operation.
REQ-016 Timing of the result:
- If start is accepted at edge t, P SHALL update and done SHALL be high in the cycle following edge t+WIDTH+1.
- P SHALL equal the lower 2*WIDTH bits of {A, Q} sign-correct, i.e. the exact product M*Q.
REQ-017 done SHALL be high for exactly one cycle per accepted start (state DONE).
REQ-018 P SHALL hold its value until the next done pulse; it SHALL NOT show intermediate values.
REQ-019 start while busy=1 SHALL be ignored: no restart, and operands are not re-sampled.
REQ-020 start held high continuously SHALL start a new operation in each IDLE cycle, giving one result every WIDTH+2 cycles.
REQ-021 Changes on M or Q after the accepting edge SHALL have no effect on the result in progress.
REQ-022 The product SHALL be exact for all operand pairs, including M = Q = -2^(WIDTH-1); no saturation or overflow flag is required.

Reset
REQ-023 With rst=1 at a rising edge, the block SHALL enter IDLE and clear P, busy, done, A, the multiplier register, Q_-1 and the counter to 0.
REQ-024 rst SHALL take priority over start and over any operation in progress; a multiplication in flight SHALL be abandoned with no done pulse.
REQ-025 The first start SHALL be accepted on the first edge after the one where rst is sampled low.

Structure
REQ-026 A shared package (mul_pkg) SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-027 A single combinational sub-module, booth_step, SHALL implement REQ-013 (add/sub select plus arithmetic shift); the FSM, counter and output registers SHALL remain in booth_multiplier.
REQ-028 Expected size: 120-250 lines of RTL in total.

Verification (WIDTH=4)
REQ-029 M=3, Q=5, start for 1 cycle -> done pulses 5 cycles after the accepting edge, P=8'h0F (15), busy high for 5 cycles.
REQ-030 M=-3, Q=5 -> P=8'hF1 (-15); M=-8, Q=-8 -> P=8'h40 (64); M=-8, Q=7 -> P=8'hC8 (-56); M=0, Q=-1 -> P=8'h00.
REQ-031 start pulsed again with M=7, Q=7 during RUN of 3*5 -> P=8'h0F, a single done pulse, the second request not executed.
REQ-032 rst asserted in the 3rd RUN cycle -> next cycle has busy=0, done=0 and P=0, and no done pulse follows; a new start then yields the correct product.
REQ-033 start held high with operands changing every cycle -> one result per 6 cycles, each result equal to the operands sampled at its accepting edge.
REQ-034 An exhaustive sweep of all 256 operand pairs SHALL be compared against a behavioural M*Q reference model with zero mismatches.
